// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : valid/ready register slice with a one-entry skid buffer
//                      and pipeline stall/flush control.
// Revision 1.0
// ============================================================================
module pipe_stage_elastic #(
  parameter int DATA_W        = 64,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              pop;

  // in_ready looks only at registered state, so out_ready never reaches it.
  assign in_ready  = (state_q != FULL) && !stall && !reset;
  assign out_valid = (state_q != EMPTY) && !stall;
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && !pop) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (accept && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_elastic : directed and randomized bench for pipe_stage_elastic
// Revision 1.0
// ============================================================================
module tb_pipe_stage_elastic;

  logic         clk = 1'b0;
  logic         rst, flush, stall, in_valid, out_ready;
  logic [127:0] in_data;

  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [1:0]   a_occ;
  logic         b_in_ready, b_out_valid;
  logic [0:0]   b_out_data;
  logic [1:0]   b_occ;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Wide instance zeroes on flush; narrow instance keeps stale data.
  pipe_stage_elastic #(.DATA_W(128), .ZERO_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .reset(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_elastic #(.DATA_W(1), .ZERO_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .reset(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[0:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  // Reference: a bounded FIFO of at most two words plus the last visible head.
  logic [127:0] mq[$];
  logic [127:0] hold_z = '0;
  logic [127:0] hold_n = '0;
  logic         m_acc, m_pop;

  always @(posedge clk) begin
    m_acc = in_valid && (mq.size() < 2) && !stall && !rst;
    m_pop = (mq.size() > 0) && !stall && out_ready;
    if (rst) begin
      mq.delete();
      hold_z = '0;
      hold_n = '0;
    end else if (flush) begin
      mq.delete();
      hold_z = '0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(in_data);
      if (mq.size() > 0) begin
        hold_z = mq[0];
        hold_n = mq[0];
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic s, input logic iv,
                     input logic [127:0] d, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_in_ready, a_out_valid, a_occ, a_out_data} !== {4'b0000, 128'h0}) begin
      n_errors++;
      $display("FAIL reset_hold: rdy/vld/occ=%b%b%0d data=%h, want 0/0/0 data=0",
               a_in_ready, a_out_valid, a_occ, a_out_data);
    end
    cyc(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_in_ready, a_out_valid, a_occ, a_out_data} !== {4'b1000, 128'h0}) begin
      n_errors++;
      $display("FAIL reset_release: rdy/vld/occ=%b%b%0d data=%h, want 1/0/0 data=0",
               a_in_ready, a_out_valid, a_occ, a_out_data);
    end
  endtask

  task automatic test_streaming;
    logic [127:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, w[i], 1);
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      if (i > 0) begin
        n_checks++;
        if ({a_out_valid, a_occ, a_out_data} !== {1'b1, 2'd1, w[i-1]}) begin
          n_errors++;
          $display("FAIL stream_out[%0d]: vld=%b occ=%0d data=%h want 1/1 %h",
                   i, a_out_valid, a_occ, a_out_data, w[i-1]);
        end
      end
    end
    cyc(0, 0, 0, 0, '0, 1);
    n_checks++;
    if ({a_out_valid, a_occ, a_out_data} !== {1'b1, 2'd1, w[7]}) begin
      n_errors++;
      $display("FAIL stream_last: vld=%b occ=%0d data=%h want 1/1 %h",
               a_out_valid, a_occ, a_out_data, w[7]);
    end
    cyc(0, 0, 0, 0, '0, 1);
    n_checks++;
    if ({a_out_valid, a_occ} !== 3'b000) begin
      n_errors++;
      $display("FAIL stream_drain: vld=%b occ=%0d want 0/0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp_d[3];
    logic         exp_r[3];
    exp_d = '{128'h11, 128'h22, 128'h33};
    exp_r = '{1'b0, 1'b1, 1'b1};
    cyc(0, 0, 0, 1, 128'h11, 0);
    cyc(0, 0, 0, 1, 128'h22, 0);
    n_checks++;
    if ({a_in_ready, a_occ, a_out_data} !== {1'b1, 2'd1, 128'h11}) begin
      n_errors++;
      $display("FAIL bp_busy: rdy=%b occ=%0d data=%h want 1/1 11", a_in_ready, a_occ, a_out_data);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 128'h33, 0);
      n_checks++;
      if ({a_in_ready, a_occ, a_out_data} !== {1'b0, 2'd2, 128'h11}) begin
        n_errors++;
        $display("FAIL bp_full[%0d]: rdy=%b occ=%0d data=%h want 0/2 11",
                 k, a_in_ready, a_occ, a_out_data);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, (k < 2), 128'h33, 1);
      n_checks++;
      if ({a_out_valid, a_in_ready, a_out_data} !== {1'b1, exp_r[k], exp_d[k]}) begin
        n_errors++;
        $display("FAIL bp_drain[%0d]: vld=%b rdy=%b data=%h want 1/%b %h",
                 k, a_out_valid, a_in_ready, a_out_data, exp_r[k], exp_d[k]);
      end
    end
    cyc(0, 0, 0, 0, '0, 1);
    n_checks++;
    if ({a_out_valid, a_occ} !== 3'b000) begin
      n_errors++;
      $display("FAIL bp_empty: vld=%b occ=%0d want 0/0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_stall;
    cyc(0, 0, 0, 1, 128'h44, 0);
    cyc(0, 0, 0, 1, 128'h55, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1, 128'h66, 1);
      n_checks++;
      if ({a_out_valid, a_in_ready, a_occ, a_out_data} !== {2'b00, 2'd2, 128'h44}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b occ=%0d data=%h want 0/0/2 44",
                 k, a_out_valid, a_in_ready, a_occ, a_out_data);
      end
    end
    cyc(0, 0, 0, 0, '0, 1);
    n_checks++;
    if ({a_out_valid, a_occ, a_out_data} !== {1'b1, 2'd2, 128'h44}) begin
      n_errors++;
      $display("FAIL stall_rel0: vld=%b occ=%0d data=%h want 1/2 44", a_out_valid, a_occ, a_out_data);
    end
    cyc(0, 0, 0, 0, '0, 1);
    n_checks++;
    if ({a_out_valid, a_occ, a_out_data} !== {1'b1, 2'd1, 128'h55}) begin
      n_errors++;
      $display("FAIL stall_rel1: vld=%b occ=%0d data=%h want 1/1 55", a_out_valid, a_occ, a_out_data);
    end
    cyc(0, 0, 0, 0, '0, 1);
  endtask

  task automatic test_flush;
    cyc(0, 0, 0, 1, 128'h77, 0);
    cyc(0, 0, 0, 1, 128'h99, 0);
    cyc(0, 1, 0, 1, 128'hEE, 1);
    cyc(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_out_valid, a_occ, a_out_data, b_out_valid, b_occ, b_out_data}
        !== {3'b000, 128'h0, 3'b000, 1'b1}) begin
      n_errors++;
      $display("FAIL flush_full: a vld/occ/data=%b/%0d/%h b vld/occ/data=%b/%0d/%b want 0/0/0 0/0/1",
               a_out_valid, a_occ, a_out_data, b_out_valid, b_occ, b_out_data);
    end
    // Flush while a word is both accepted and popped: the accepted word vanishes.
    cyc(0, 0, 0, 1, 128'h5B, 0);
    cyc(0, 1, 0, 1, 128'hC4, 1);
    n_checks++;
    if ({a_in_ready, a_out_valid} !== 2'b11) begin
      n_errors++;
      $display("FAIL flush_hs: rdy=%b vld=%b want 1/1", a_in_ready, a_out_valid);
    end
    cyc(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_out_valid, a_occ, a_out_data, b_occ, b_out_data} !== {3'b000, 128'h0, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL flush_busy: vld=%b occ=%0d data=%h b_occ=%0d b_data=%b want 0/0/0 0/1",
               a_out_valid, a_occ, a_out_data, b_occ, b_out_data);
    end
    cyc(0, 0, 0, 1, 128'h3C, 0);
    cyc(0, 1, 1, 1, 128'h3D, 0);
    cyc(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_out_valid, a_occ} !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_stall: vld=%b occ=%0d want 0/0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 0, 1, 128'h13, 0);
    cyc(0, 0, 0, 1, 128'h35, 0);
    cyc(1, 0, 1, 1, 128'h57, 1);
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_rdy: got %b want 0", a_in_ready);
    end
    cyc(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({a_in_ready, a_out_valid, a_occ, a_out_data, b_out_data} !== {4'b1000, 128'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL rstmid_release: rdy/vld/occ=%b%b%0d data=%h b_data=%b want 1/0/0 0 0",
               a_in_ready, a_out_valid, a_occ, a_out_data, b_out_data);
    end
  endtask

  task automatic test_random;
    logic [127:0] ea, eb;
    logic [3:0]   ectl;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6),
          {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 6));
      ectl = {(mq.size() < 2) && !stall && !rst, (mq.size() > 0) && !stall, 2'(mq.size())};
      ea   = (mq.size() > 0) ? mq[0] : hold_z;
      eb   = (mq.size() > 0) ? mq[0] : hold_n;
      n_checks++;
      if ({a_in_ready, a_out_valid, a_occ, a_out_data} !== {ectl, ea}) begin
        n_errors++;
        $display("FAIL rand_a[%0d]: rdy/vld/occ=%b data=%h want %b %h",
                 i, {a_in_ready, a_out_valid, a_occ}, a_out_data, ectl, ea);
      end
      n_checks++;
      if ({b_in_ready, b_out_valid, b_occ, b_out_data} !== {ectl, eb[0]}) begin
        n_errors++;
        $display("FAIL rand_b[%0d]: rdy/vld/occ/data=%b want %b",
                 i, {b_in_ready, b_out_valid, b_occ, b_out_data}, {ectl, eb[0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
